// File: rtl/key_pkg.sv
// Shared types for the key conditioner: per-channel FSM state and counter sizing.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } key_state_t;

  // Counter must hold CNT_LONG only when the long-press timer is built.
  function automatic int cnt_width(input int deb, input int lng, input bit long_en);
    int m;
    m = (long_en && (lng > deb)) ? lng : deb;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, press/release/long pulses; pin-to-press CNT_DEB+3 cycles.
// Long-press timing is built only when KEY_LONG_PRESS_EN is defined; otherwise key_long stays 0.
module key_chan
  import key_pkg::*;
#(
  parameter int CNT_DEB    = 249999,
  parameter int CNT_LONG   = 49999999,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_level
);

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int             CW       = cnt_width(CNT_DEB, CNT_LONG, LONG_EN);
  localparam logic [CW-1:0]  DEB_LAST = CW'(CNT_DEB - 1);
  localparam logic           REL_LVL  = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          p;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Sync flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{REL_LVL}};
    else        sync <= {sync[0], key};
  end

  assign p = sync[1] ^ REL_LVL;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_MAX  = CW'(CNT_LONG);
  localparam logic [CW-1:0] LONG_LAST = CW'(CNT_LONG - 1);
  logic long_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_level   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= 1'b0;
      long_done   <= 1'b0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      key_long    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_DEB;
            cnt   <= '0;
          end
        end
        PRESS_DEB: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!p) begin
            state <= REL_DEB;
            cnt   <= '0;
          end
`ifdef KEY_LONG_PRESS_EN
          else begin
            if (cnt != LONG_MAX) cnt <= cnt + 1'b1;
            if ((cnt == LONG_LAST) && !long_done) begin
              key_long  <= 1'b1;
              long_done <= 1'b1;
            end
          end
`endif
        end
        REL_DEB: begin
          // A bounce back to pressed resumes the same press; long_done is kept.
          if (p) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_done   <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef KEY_LONG_PRESS_EN
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter_multi.sv
// KEY_NUM independent debounced key channels; all outputs registered, pin-to-press CNT_DEB+3 cycles.
// Long-press pulses only when KEY_LONG_PRESS_EN is defined.
module key_filter_multi
  import key_pkg::*;
#(
  parameter int KEY_NUM    = 4,
  parameter int CNT_DEB    = 249999,
  parameter int CNT_LONG   = 49999999,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_level
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_chan #(
      .CNT_DEB    (CNT_DEB),
      .CNT_LONG   (CNT_LONG),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i]),
      .key_level   (key_level[i])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi with CNT_DEB=4, CNT_LONG=10, two active-low keys.
module tb_key_filter_multi;

  localparam int KN = 2;
  localparam int CD = 4;
  localparam int CL = 10;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] key;
  logic [KN-1:0] key_press, key_release, key_long, key_level;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_filter_multi #(
    .KEY_NUM    (KN),
    .CNT_DEB    (CD),
    .CNT_LONG   (CL),
    .ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .key_level   (key_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    key   = 2'b11;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_press, key_release, key_long, key_level} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got=%b exp=00000000", {key_press, key_release, key_long, key_level});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({key_press, key_release, key_long, key_level} !== 8'h00) begin
        errors++;
        $display("FAIL idle_after_reset k=%0d got=%b exp=00000000", k, {key_press, key_release, key_long, key_level});
      end
    end
  endtask

  task automatic test_clean_press();
    key[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (key_press !== ((k == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_press k=%0d got=%b exp=%b", k, key_press, (k == 7) ? 2'b01 : 2'b00);
      end
      checks++;
      if (key_level !== ((k >= 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_level k=%0d got=%b exp=%b", k, key_level, (k >= 7) ? 2'b01 : 2'b00);
      end
      checks++;
      if (key_release !== 2'b00) begin
        errors++;
        $display("FAIL clean_no_release k=%0d got=%b exp=00", k, key_release);
      end
    end
    key[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (key_release !== ((k == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL clean_release k=%0d got=%b exp=%b", k, key_release, (k == 7) ? 2'b01 : 2'b00);
      end
      checks++;
      if (key_level !== ((k >= 7) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL release_level k=%0d got=%b exp=%b", k, key_level, (k >= 7) ? 2'b00 : 2'b01);
      end
      checks++;
      if (key_press !== 2'b00) begin
        errors++;
        $display("FAIL release_no_press k=%0d got=%b exp=00", k, key_press);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_bounce();
    key[0] = 1'b0;
    repeat (3) tick();
    key[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({key_press, key_level} !== 4'b0000) begin
        errors++;
        $display("FAIL bounce k=%0d press_level=%b exp=0000", k, {key_press, key_level});
      end
    end
  endtask

  task automatic test_long_press();
    logic [KN-1:0] exp_long;
    key[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_long = (LONG_EN && (k == 17)) ? 2'b01 : 2'b00;
      checks++;
      if (key_press !== ((k == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL long_press_edge k=%0d got=%b exp=%b", k, key_press, (k == 7) ? 2'b01 : 2'b00);
      end
      checks++;
      if (key_long !== exp_long) begin
        errors++;
        $display("FAIL long_pulse k=%0d got=%b exp=%b", k, key_long, exp_long);
      end
    end
  endtask

  task automatic test_release_glitch();
    key[0] = 1'b1;
    repeat (2) tick();
    key[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if ({key_release, key_long, key_level} !== 6'b00_00_01) begin
        errors++;
        $display("FAIL glitch k=%0d rel_long_level=%b exp=000001", k, {key_release, key_long, key_level});
      end
    end
    key[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (key_release !== ((k == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL final_release k=%0d got=%b exp=%b", k, key_release, (k == 7) ? 2'b01 : 2'b00);
      end
      checks++;
      if (key_level !== ((k >= 7) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL final_level k=%0d got=%b exp=%b", k, key_level, (k >= 7) ? 2'b00 : 2'b01);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    key = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (key_press !== ((k == 7) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_press k=%0d got=%b exp=%b", k, key_press, (k == 7) ? 2'b11 : 2'b00);
      end
    end
    key = 2'b11;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (key_release !== ((k == 7) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL simul_release k=%0d got=%b exp=%b", k, key_release, (k == 7) ? 2'b11 : 2'b00);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      key[0] = 1'b0;
      repeat ((pass == 0) ? 4 : 9) tick();
      if (pass == 1) begin
        checks++;
        if (key_level !== 2'b01) begin
          errors++;
          $display("FAIL held_before_reset got=%b exp=01", key_level);
        end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({key_press, key_release, key_long, key_level} !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid pass=%0d got=%b exp=00000000", pass, {key_press, key_release, key_long, key_level});
      end
      key = 2'b11;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        tick();
        checks++;
        if ({key_press, key_release, key_long, key_level} !== 8'h00) begin
          errors++;
          $display("FAIL after_reset pass=%0d k=%0d got=%b exp=00000000", pass, k, {key_press, key_release, key_long, key_level});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
